// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder and its bench.
//   state_t      : responder FSM encoding
//   WORD_BYTES   : bytes per array word
//   ERR_*        : bit positions of the rejection reasons
//   err_reasons(): per-reason rejection vector for a request
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES   = 4;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE    = 1;
  localparam int ERR_CONFLICT = 2;
  localparam int ERR_W        = 3;

  // aw is the word-address width; anything at or above byte 2**(aw+2) is out of range.
  function automatic logic [ERR_W-1:0] err_reasons(input logic [31:0] addr,
                                                   input logic        rd,
                                                   input logic        wr,
                                                   input int          aw);
    logic [ERR_W-1:0] r;
    r               = '0;
    r[ERR_MISALIGN] = |addr[1:0];
    r[ERR_RANGE]    = |(addr >> (aw + 2));
    r[ERR_CONFLICT] = rd & wr;
    return r;
  endfunction

endpackage

// File: rtl/data_mem_responder_wait_counter.sv
// wait_counter: loadable down-counter with a zero flag, used to count
// memory wait states.
//   clk, rst  : clock, async active-high reset
//   load      : load load_val (wins over dec)
//   dec       : decrement, saturating at zero
//   load_val  : value loaded on load
//   zero      : count is zero
module wait_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      count <= '0;
    else if (load)                count <= load_val;
    else if (dec && count != '0)  count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory answering the CPU data port
// with WAIT_CYCLES wait states and a one-cycle ready pulse.
//   clk, rst      : clock, async active-high reset
//   addr, wdata   : byte address and store data, sampled at acceptance
//   rd_en, wr_en  : load / store request, held until ready
//   rdata         : load data, updated only by error-free reads
//   ready, err    : one-cycle response pulse and rejection flag
//   rd_count, wr_count : error-free response counters, present only when
//                        DATA_MEM_RESPONDER_STATS_EN is defined
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        rd_en,
  input  logic        wr_en,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
`ifdef DATA_MEM_RESPONDER_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  // WAIT is held for WAIT_CYCLES cycles: the counter starts at WAIT_CYCLES-1
  // and RESP follows the cycle in which it reads zero.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t        state, state_nxt;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          rd_q, wr_q, err_q;
  logic [31:0]   mem [2**AW];

  logic          accept, req_err, cnt_zero;
  logic          rd_go;
  logic [AW-1:0] rd_idx;

  assign accept  = (state == IDLE) && (rd_en | wr_en);
  assign req_err = |err_reasons(addr, rd_en, wr_en, AW);

  wait_counter #(.CW(4)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .dec      (state == WAIT),
    .load_val (WAIT_LOAD),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:    if (cnt_zero) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= addr[AW+1:2];
      wdata_q <= wdata;
      rd_q    <= rd_en;
      wr_q    <= wr_en;
      err_q   <= req_err;
    end
  end

  // rdata is loaded on the edge entering RESP. With no wait states that edge
  // is the accepting one, so the live request is used instead of the latches.
  always_comb begin
    rd_go  = 1'b0;
    rd_idx = idx_q;
    if (state == IDLE) begin
      rd_idx = addr[AW+1:2];
      rd_go  = (state_nxt == RESP) && rd_en && !req_err;
    end else begin
      rd_go  = (state_nxt == RESP) && rd_q && !err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdata <= '0;
    else if (rd_go) rdata <= mem[rd_idx];
  end

  // Array is not reset; the rst term keeps a reset landing on the RESP edge
  // from committing the store.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && wr_q && !err_q) mem[idx_q] <= wdata_q;
  end

  assign ready = (state == RESP);
  assign err   = ready & err_q;

`ifdef DATA_MEM_RESPONDER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == RESP && !err_q) begin
      if (rd_q) rd_count <= rd_count + 16'd1;
      if (wr_q) wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule
